// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: four-requester arbiter for the shared priority encoder.
// Selects one owner (fixed priority or round-robin), holds the grant until
// the owner releases, then inserts one dead TURN cycle before the next grant.
// Optional build macro GRANT_TIMEOUT_EN adds a hold counter that force-releases
// an owner after MAX_HOLD consecutive grant cycles.
module rr_priority_arbiter #(
    parameter bit          RR       = 1'b1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StTurn  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] win_q, win_d;
    logic [1:0] last_q, last_d;
    logic [3:0] gnt_q, gnt_d;

    // Arbitration result for the current req.
    logic [1:0] ord0, ord1, ord2, ord3;
    logic       sel_found;
    logic [1:0] sel_idx;

    // Forced release request from the hold counter (constant 0 without it).
    logic hold_expire;

`ifdef GRANT_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic [7:0] hold_inc;

    // Hold counter: zero outside GRANT, so it is clear on every GRANT entry.
    always_comb begin
        hold_inc    = hold_q + 8'd1;
        hold_d      = 8'd0;
        hold_expire = 1'b0;
        if (state_q == StGrant) begin
            hold_d = hold_inc;
            // hold_inc counts this grant cycle; release on the edge ending cycle MAX_HOLD.
            if (32'(hold_inc) >= MAX_HOLD) begin
                hold_expire = 1'b1;
            end
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expire = 1'b0;
`endif

    // Search order: round-robin starts just below the last owner (mod 4),
    // fixed priority is always 3,2,1,0. With last=0 both orders coincide.
    always_comb begin
        if (RR) begin
            ord0 = last_q - 2'd1;
            ord1 = last_q - 2'd2;
            ord2 = last_q - 2'd3;
            ord3 = last_q;
        end else begin
            ord0 = 2'd3;
            ord1 = 2'd2;
            ord2 = 2'd1;
            ord3 = 2'd0;
        end
        sel_found = |req;
        sel_idx   = 2'd0;
        if (req[ord0]) begin
            sel_idx = ord0;
        end else if (req[ord1]) begin
            sel_idx = ord1;
        end else if (req[ord2]) begin
            sel_idx = ord2;
        end else begin
            sel_idx = ord3;
        end
    end

    // Next-state logic: grant from IDLE/TURN, hold in GRANT, one dead TURN cycle.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle, StTurn: begin
                if (sel_found) begin
                    state_d = StGrant;
                    win_d   = sel_idx;
                    gnt_d   = 4'b0001 << sel_idx;
                end else begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                end
            end
            StGrant: begin
                // Other requesters are ignored; only the owner's release (or
                // a timeout) ends the grant.
                if (!req[win_q] || hold_expire) begin
                    state_d = StTurn;
                    gnt_d   = 4'b0000;
                    last_d  = win_q;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and grant registers; async reset drops the grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            win_q   <= 2'd0;
            last_q  <= 2'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    // Outputs derived only from registers; win_q is stale outside GRANT so mask it.
    always_comb begin
        gnt       = gnt_q;
        gnt_valid = |gnt_q;
        gnt_idx   = gnt_valid ? win_q : 2'b00;
        busy      = (state_q != StIdle);
    end

    // Simulation-only sanity checks: legal MAX_HOLD and at most one grant bit.
    always_comb begin
        assert (MAX_HOLD >= 1 && MAX_HOLD <= 255);
        assert ($onehot0(gnt_q));
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter: one fixed-priority and one
// round-robin instance share req/reset. Stimulus pushes hand-computed
// expectations; a monitor pops and compares one entry per clock.
module tb_rr_priority_arbiter;

`ifdef GRANT_TIMEOUT_EN
    localparam int unsigned MaxHold = 3;
`else
    localparam int unsigned MaxHold = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] gnt_fp, gnt_rr;
    logic [1:0] idx_fp, idx_rr;
    logic       val_fp, val_rr;
    logic       busy_fp, busy_rr;

    rr_priority_arbiter #(.RR(1'b0), .MAX_HOLD(MaxHold)) dut_fp (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt_fp),
        .gnt_idx   (idx_fp),
        .gnt_valid (val_fp),
        .busy      (busy_fp)
    );

    rr_priority_arbiter #(.RR(1'b1), .MAX_HOLD(MaxHold)) dut_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt_rr),
        .gnt_idx   (idx_rr),
        .gnt_valid (val_rr),
        .busy      (busy_rr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g_fp;
        logic [3:0] g_rr;
        logic       b_fp;
        logic       b_rr;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   step_id = 0;

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    task automatic check(input string what, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", what, id, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int id, input logic [3:0] g,
                             input logic [1:0] idx, input logic v, input logic b,
                             input logic [3:0] eg, input logic eb);
        check({tag, "_gnt"}, id, 32'(g), 32'(eg));
        check({tag, "_idx"}, id, 32'(idx), 32'(enc(eg)));
        check({tag, "_valid"}, id, 32'(v), 32'(|eg));
        check({tag, "_busy"}, id, 32'(b), 32'(eb));
    endtask

    // Drive req at the falling edge; expectation is for after the next rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] efp, input logic [3:0] err,
                        input logic bfp, input logic brr);
        exp_t e;
        @(negedge clk);
        req     = r;
        step_id++;
        e.g_fp  = efp;
        e.g_rr  = err;
        e.b_fp  = bfp;
        e.b_rr  = brr;
        e.id    = step_id;
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_dut("fp", e.id, gnt_fp, idx_fp, val_fp, busy_fp, e.g_fp, e.b_fp);
                check_dut("rr", e.id, gnt_rr, idx_rr, val_rr, busy_rr, e.g_rr, e.b_rr);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        check_dut("fp_reset", 0, gnt_fp, idx_fp, val_fp, busy_fp, 4'b0000, 1'b0);
        check_dut("rr_reset", 0, gnt_rr, idx_rr, val_rr, busy_rr, 4'b0000, 1'b0);
        reset = 1'b0;

        // Idle with no requests.
        repeat (10) step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

`ifdef GRANT_TIMEOUT_EN
        // Timeout with MAX_HOLD=3, req={A,D} held: RR alternates, fixed re-grants A.
        for (int k = 0; k < 3; k++) begin
            step(4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1);
            step(4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1);
            step(4'b1001, 4'b1000, 4'b1000, 1'b1, 1'b1);
            step(4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1);
            if (k == 1) break;
            step(4'b1001, 4'b1000, 4'b0001, 1'b1, 1'b1);
            step(4'b1001, 4'b1000, 4'b0001, 1'b1, 1'b1);
            step(4'b1001, 4'b1000, 4'b0001, 1'b1, 1'b1);
            step(4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1);
        end
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
`else
        // req=0011: bit 1 wins, release -> TURN, then bit 0.
        step(4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b1);
        step(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Owner 2 holds against a higher request, then 3 wins after TURN.
        step(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1);
        step(4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b1);
        step(4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b1);
        step(4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Reset between edges during a grant drops everything at once.
        step(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        check_dut("fp_midreset", step_id, gnt_fp, idx_fp, val_fp, busy_fp, 4'b0000, 1'b0);
        check_dut("rr_midreset", step_id, gnt_rr, idx_rr, val_rr, busy_rr, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // All four requesting, owners drop for one cycle after two: RR 3,2,1,0,3.
        step(4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b1);
        step(4'b0111, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b0100, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b0100, 1'b1, 1'b1);
        step(4'b1011, 4'b1000, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b0010, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b0010, 1'b1, 1'b1);
        step(4'b1101, 4'b1000, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b0001, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b0001, 1'b1, 1'b1);
        step(4'b1110, 4'b1000, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b1000, 4'b1000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", step_id, 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Sequences a 4-input priority-encoding resource so that exactly one of four requesters holds it at a time.
- Requests use the encoder ordering: req[3:0] = {A,B,C,D}. The winner index equals its bit position, so the encoded index matches the {W,Y} encoding of the priority encoder.
- Provides fixed-priority or round-robin selection, grant hold until release, and a one-cycle turnaround between owners.
- Sits between the lab's request sources and the shared encoder/datapath.

Parameters:
- RR, 1, selection mode: 1 = round-robin, 0 = fixed priority (bit 3 highest).
- MAX_HOLD, 8, maximum consecutive GRANT cycles per owner. Legal range 1..255. Used only when GRANT_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  request vector {A,B,C,D}; level-sensitive, held by the requester for as long as it wants ownership
- gnt  output  4  one-hot grant, registered
- gnt_idx  output  2  encoded index of the current owner ({W,Y}); 2'b00 when gnt_valid=0
- gnt_valid  output  1  high while any grant is asserted
- busy  output  1  high in GRANT and TURN states

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
  - Reset forces state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, busy=0, last=2'd0, hold counter=0.
  - Reset asserted mid-GRANT drops the grant immediately, without waiting for a clock edge.
- States:
  - IDLE: no owner.
  - GRANT: owner held in register win[1:0].
  - TURN: one dead cycle after a release.
- IDLE/TURN arbitration:
  - If req != 0 at a rising edge, select the winner, register gnt/gnt_idx/gnt_valid, and go to GRANT.
  - Latency is 1 cycle from the sampled request to the visible grant.
  - If req == 0, go to (or stay in) IDLE.
- Selection:
  - RR=0: highest set bit wins (3,2,1,0).
  - RR=1: search order is (last-1), (last-2), (last-3), last, all mod 4; the first set bit wins. With last=0 after reset the order is 3,2,1,0, identical to fixed priority.
- GRANT:
  - Ownership holds while req[win]=1. Other requests are ignored, and gnt never changes owner directly.
  - When req[win]=0 is sampled at an edge: clear gnt that edge, set last <= win, go to TURN.
- TURN:
  - gnt=0 and busy=1 for exactly one cycle, then arbitrate as in IDLE.
  - Consequence: minimum gap between two grants is one cycle.
- Simultaneous events:
  - A new request arriving in the same cycle the owner drops is served after TURN.
  - A request pulse shorter than one cycle that misses the sampling edge is ignored.
- Invariants: gnt is always zero or one-hot, and gnt_idx == encode(gnt).

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD while req[win] is still 1, the arbiter force-releases: clear gnt, last <= win, go to TURN.
  - With RR=1 the preempted requester becomes lowest priority.
  - With RR=0 it can win again after TURN if it is still the highest request.
- Undefined: no counter is built, MAX_HOLD is unused, and ownership lasts until the owner's request drops.

Test Plan:
1. Reset applied mid-grant (req=4'b0010 granted, reset pulsed between edges) -> gnt=0000, gnt_valid=0, busy=0 immediately; after release, first grant again follows order 3,2,1,0.
2. RR=0, req=4'b0011 -> one edge later gnt=0010, gnt_idx=01; drop req[1] -> TURN cycle with gnt=0000, busy=1; next edge gnt=0001, gnt_idx=00.
3. RR=1, req held at 4'b1111, each owner drops its bit for one cycle after 2 cycles and then reasserts -> grant sequence 3,2,1,0,3 with one zero-grant cycle between grants.
4. Owner 2 holding, req changes 4'b0100 -> 4'b1100 -> gnt stays 0100 with no preemption; drop bit 2 -> after TURN, gnt=1000.
5. GRANT_TIMEOUT_EN defined, RR=1, MAX_HOLD=3, req=4'b1001 held constant -> gnt=1000 for 3 cycles, 1 TURN cycle, gnt=0001 for 3 cycles, repeating.
6. req=0000 for 10 cycles after reset -> state IDLE, all outputs 0, busy=0.
